rv_wb_rr_arbiter: RTL and testbench
===================================

Name: rv_wb_rr_arbiter

Overview:
- Round-robin arbiter that shares the single register-file writeback port between the commit sources: ALU, LD, CSR, FPU and GPU.
- Sits between the execute-unit commit interfaces and the issue-stage writeback interface.
- Grants at most one requester per cycle and registers the winner's payload into a one-entry output stage.
- Sustains one writeback per cycle under continuous downstream ready.

Parameters:
- NUM_REQS, 5, number of commit requesters; index 0=ALU, 1=LD, 2=CSR, 3=FPU, 4=GPU.
- DATAW, `UUID_BITS+`NW_BITS+`NUM_THREADS+32+`NUM_THREADS*32+`NR_BITS+2, packed payload width {uuid,wid,tmask,PC,data,rd,wb,eop}.
- IDXW, $clog2(NUM_REQS), grant index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQS  per-requester valid.
- req_data  in  NUM_REQS*DATAW  payloads; requester i occupies bits [i*DATAW +: DATAW].
- req_ready  out  NUM_REQS  per-requester ready; combinational.
- wb_valid  out  1  registered writeback valid.
- wb_data  out  DATAW  registered writeback payload.
- wb_idx  out  IDXW  registered index of the source of wb_data.
- wb_ready  in  1  writeback consumer ready.

Behaviour:
- Reset (reset=0, async): wb_valid=0, wb_data=0, wb_idx=0, priority pointer ptr=0.
- Output stage has two states: EMPTY (wb_valid=0) and FULL (wb_valid=1).
- can_accept = !wb_valid || wb_ready.
- Grant selection:
  - Scan req_valid starting at ptr, wrapping modulo NUM_REQS; the first asserted index wins.
  - Grant is one-hot or zero.
  - Combinational from req_valid and ptr only; must not depend on req_data.
- req_ready[i] = grant[i] && can_accept.
  - At most one req_ready high per cycle.
  - req_ready must not depend on wb_valid of a grant issued in the same cycle.
- Fire (any req_valid[i] && req_ready[i]):
  - Next cycle: wb_valid=1, wb_data=req_data[i], wb_idx=i.
  - Next ptr = (i+1) mod NUM_REQS; i=NUM_REQS-1 wraps to 0.
- No fire while can_accept: wb_valid becomes 0 (if wb_ready consumed the entry) or stays 0. ptr holds.
- FULL && !wb_ready:
  - wb_valid, wb_data and wb_idx hold stable.
  - All req_ready=0; ptr holds.
- FULL && wb_ready && request pending: back-to-back transfer; the new payload replaces the consumed one in the same edge. This is the full-throughput case.
- Latency is exactly 1 cycle from fire to wb_valid.
- Fairness: any continuously valid requester is granted within NUM_REQS fires.
- Requesters must hold valid and payload until ready. Dropping valid without ready is legal, and the arbiter takes no action.
- Reset mid-transfer: a pending output is discarded and no requester sees a spurious fire. Requesters see req_ready=0 during reset because wb_valid=0 and grant is masked while reset is asserted.

Optional Feature:
- Macro RV_WB_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cycles, width NUM_REQS*32.
  - Per-requester 32-bit counter increments each cycle req_valid[i] && !req_ready[i].
  - Counters wrap at 2^32 and reset to 0.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define header holds:
  - requester index constants WB_REQ_ALU=0, WB_REQ_LD=1, WB_REQ_CSR=2, WB_REQ_FPU=3, WB_REQ_GPU=4;
  - the WB payload field offsets and DATAW expression, so the commit stage packs and unpacks consistently.
- One natural sub-module: rv_rr_select, the combinational rotating priority selector. Inputs: req vector and ptr. Outputs: one-hot grant, grant index and valid. Reusable by other arbiters.
- The output register and pointer stay in the top level.

Test Plan:
- Reset behaviour: assert reset=0 with req_valid=5'b11111 -> req_ready=0, wb_valid=0, wb_idx=0; release -> first grant to index 0.
- Full rotation: hold req_valid=5'b11111, wb_ready=1 for 10 cycles -> wb_idx sequence 0,1,2,3,4,0,1,2,3,4; wb_valid=1 from cycle 1 onward with no bubbles.
- Wrap-around: ptr=4 via a single grant to 3, then req_valid=5'b10001 -> grant 4, then 0.
- Backpressure: FULL with wb_idx=2, wb_ready=0 for 3 cycles, req_valid=5'b01000 -> wb_data/wb_idx stable, req_ready=0; wb_ready=1 -> index 3 fires that cycle and appears next.
- Sparse traffic: single pulse on index 1 with payload PC=0x8000_0010, wb_ready=1 -> one-cycle wb_valid with matching wb_data and wb_idx=1; next cycle wb_valid=0.
- RV_WB_ARB_PERF_EN: index 4 valid while FULL and wb_ready=0 for 7 cycles -> perf_stall_cycles[4*32 +: 32]=7; other counters 0.

Source files
------------

// File: rtl/rv_wb_rr_arbiter_pkg.sv
// rtl/rv_wb_rr_arbiter_pkg.sv - writeback payload layout, requester indices and arbiter state type
`ifndef UUID_BITS
`define UUID_BITS 8
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

package rv_wb_rr_arbiter_pkg;

    // Commit sources sharing the register-file writeback port
    localparam int WB_REQ_ALU  = 0;
    localparam int WB_REQ_LD   = 1;
    localparam int WB_REQ_CSR  = 2;
    localparam int WB_REQ_FPU  = 3;
    localparam int WB_REQ_GPU  = 4;
    localparam int WB_NUM_REQS = 5;

    localparam int WB_UUID_BITS   = `UUID_BITS;
    localparam int WB_NW_BITS     = `NW_BITS;
    localparam int WB_NUM_THREADS = `NUM_THREADS;
    localparam int WB_NR_BITS     = `NR_BITS;

    // Payload packing, MSB to LSB: {uuid, wid, tmask, PC, data, rd, wb, eop}
    localparam int WB_DATAW = `UUID_BITS + `NW_BITS + `NUM_THREADS + 32
                            + `NUM_THREADS * 32 + `NR_BITS + 2;

    localparam int WB_EOP_LSB   = 0;
    localparam int WB_WB_LSB    = 1;
    localparam int WB_RD_LSB    = 2;
    localparam int WB_DATA_LSB  = WB_RD_LSB + WB_NR_BITS;
    localparam int WB_PC_LSB    = WB_DATA_LSB + WB_NUM_THREADS * 32;
    localparam int WB_TMASK_LSB = WB_PC_LSB + 32;
    localparam int WB_WID_LSB   = WB_TMASK_LSB + WB_NUM_THREADS;
    localparam int WB_UUID_LSB  = WB_WID_LSB + WB_NW_BITS;

    // Output stage occupancy
    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    // Commit stages build their payload through this so field order never drifts
    function automatic logic [WB_DATAW-1:0] wb_pack(
        input logic [WB_UUID_BITS-1:0]      uuid,
        input logic [WB_NW_BITS-1:0]        wid,
        input logic [WB_NUM_THREADS-1:0]    tmask,
        input logic [31:0]                  pc,
        input logic [WB_NUM_THREADS*32-1:0] data,
        input logic [WB_NR_BITS-1:0]        rd,
        input logic                         wb,
        input logic                         eop
    );
        return {uuid, wid, tmask, pc, data, rd, wb, eop};
    endfunction

endpackage

// File: rtl/rv_wb_rr_arbiter_select.sv
// rtl/rv_wb_rr_arbiter_select.sv - rotating-priority one-hot selector (rv_rr_select)
module rv_rr_select #(
    parameter int N    = 5,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid
);

    // Scan from ptr upward with wrap; first asserted request wins. ptr is assumed < N.
    always_comb begin
        int j;
        logic [IDXW-1:0] idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = IDXW'(j);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/rv_wb_rr_arbiter.sv
// rtl/rv_wb_rr_arbiter.sv - round-robin writeback arbiter; optional stall counters under RV_WB_ARB_PERF_EN
module rv_wb_rr_arbiter
    import rv_wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQS = WB_NUM_REQS,
    parameter int DATAW    = WB_DATAW,
    parameter int IDXW     = $clog2(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      wb_valid,
    output logic [DATAW-1:0]          wb_data,
    output logic [IDXW-1:0]           wb_idx,
    input  logic                      wb_ready
`ifdef RV_WB_ARB_PERF_EN
    ,
    output logic [NUM_REQS*32-1:0]    perf_stall_cycles
`endif
);

    wb_state_e           state_q, state_d;
    logic [DATAW-1:0]    data_q, data_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [IDXW-1:0]     ptr_q, ptr_d;

    logic [NUM_REQS-1:0] grant;
    logic [IDXW-1:0]     grant_idx;
    logic                grant_valid;
    logic                can_accept;
    logic                fire;

    // Grant depends only on valids and the pointer, never on payload
    rv_rr_select #(
        .N    (NUM_REQS),
        .IDXW (IDXW)
    ) u_select (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Offer the grant when the slot is empty or being drained; mask everything while in reset
    always_comb begin
        can_accept = (state_q == WB_EMPTY) || wb_ready;
        req_ready  = (reset && can_accept) ? grant : '0;
        fire       = reset && can_accept && grant_valid;
    end

    // Output-stage next state, captured payload and rotating pointer
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            WB_EMPTY: begin
                if (fire) begin
                    state_d = WB_FULL;
                end
            end
            WB_FULL: begin
                if (wb_ready && !fire) begin
                    state_d = WB_EMPTY;
                end
            end
            default: state_d = WB_EMPTY;
        endcase
        if (fire) begin
            idx_d = grant_idx;
            ptr_d = (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (grant[i]) begin
                    data_d = req_data[i*DATAW +: DATAW];
                end
            end
        end
    end

    // State register; reset discards any pending output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WB_EMPTY;
            data_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign wb_valid = (state_q == WB_FULL);
    assign wb_data  = data_q;
    assign wb_idx   = idx_q;

`ifdef RV_WB_ARB_PERF_EN
    logic [31:0] stall_q [NUM_REQS];
    logic [31:0] stall_d [NUM_REQS];

    // Count cycles each requester waits with valid high; wraps naturally at 2^32
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            stall_d[i] = stall_q[i] + {31'd0, (req_valid[i] && !req_ready[i])};
        end
    end

    // Stall counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                stall_q[i] <= stall_d[i];
            end
        end
    end

    // Flatten counters onto the perf port, requester i at [i*32 +: 32]
    always_comb begin
        perf_stall_cycles = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            perf_stall_cycles[i*32 +: 32] = stall_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_rv_wb_rr_arbiter.sv
// tb/tb_rv_wb_rr_arbiter.sv - scoreboard bench for rv_wb_rr_arbiter
`timescale 1ns/1ps
module tb_rv_wb_rr_arbiter;
    import rv_wb_rr_arbiter_pkg::*;

    localparam int N  = WB_NUM_REQS;
    localparam int W  = WB_DATAW;
    localparam int IW = $clog2(N);

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            wb_valid;
    logic [W-1:0]    wb_data;
    logic [IW-1:0]   wb_idx;
    logic            wb_ready = 1'b1;
`ifdef RV_WB_ARB_PERF_EN
    logic [N*32-1:0] perf_stall_cycles;
`endif

    logic [W-1:0] req_pl [N];

    typedef struct {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      m_ptr;
    bit      m_valid;
    int      n_checks;
    int      n_pass;

    rv_wb_rr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_idx    (wb_idx),
        .wb_ready  (wb_ready)
`ifdef RV_WB_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = req_pl[i];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] new_payload();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j[IW-1:0]]) return j;
        end
        return -1;
    endfunction

    // One clock cycle: check against the model at mid-cycle, advance model, clock, refresh payloads.
    task automatic step();
        int           g;
        bit           can_acc;
        bit           fire;
        logic [N-1:0] exp_ready;
        #1;
        can_acc   = !m_valid || wb_ready;
        g         = model_grant(req_valid, m_ptr);
        exp_ready = '0;
        if (can_acc && g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("wb_valid", wb_valid, m_valid);
        check("sb_depth", sb_q.size(), m_valid ? 1 : 0);
        if (m_valid && sb_q.size() > 0) begin
            check("wb_idx", wb_idx, sb_q[0].idx);
            check("wb_data", wb_data, sb_q[0].data);
            if (wb_ready) void'(sb_q.pop_front());
        end
        fire = can_acc && (g >= 0);
        if (fire) begin
            sb_q.push_back('{idx: IW'(g), data: req_pl[g]});
            m_ptr   = (g + 1) % N;
            m_valid = 1'b1;
        end else if (can_acc) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (fire) req_pl[g] = new_payload();
    endtask

    // Called at a negedge; asserts reset asynchronously and checks outputs before any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_idx", wb_idx, 0);
        check("rst_wb_data", wb_data, 0);
        m_ptr   = 0;
        m_valid = 1'b0;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [W-1:0] held;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < N; i++) req_pl[i] = new_payload();

        // Reset with all requesters asserting, then full rotation
        req_valid = 5'b11111;
        wb_ready  = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step();
            check("rot_valid", wb_valid, 1);
            check("rot_idx", wb_idx, k % N);
        end

        // Wrap-around from ptr=4
        req_valid = 5'b00000; step();
        req_valid = 5'b01000; step();
        req_valid = 5'b10001; step();
        check("wrap_idx4", wb_idx, 4);
        step();
        check("wrap_idx0", wb_idx, 0);
        req_valid = 5'b00000; step();

        // Backpressure holds output and blocks requesters
        req_valid = 5'b00100; step();
        held      = wb_data;
        wb_ready  = 1'b0;
        req_valid = 5'b01000;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_idx", wb_idx, 2);
            check("bp_data", wb_data, held);
            check("bp_ready", req_ready, '0);
        end
        wb_ready = 1'b1;
        step();
        check("bp_release_idx", wb_idx, 3);
        req_valid = 5'b00000; step();

        // Sparse single pulse on LD
        req_pl[WB_REQ_LD] = wb_pack(8'h5a, 2'd1, 2'b11, 32'h8000_0010, 64'h1234_5678_9abc_def0, 5'd7, 1'b1, 1'b1);
        req_valid = 5'b00010;
        step();
        check("sparse_valid", wb_valid, 1);
        check("sparse_idx", wb_idx, WB_REQ_LD);
        check("sparse_pc", wb_data[WB_PC_LSB +: 32], 32'h8000_0010);
        req_valid = 5'b00000;
        step();
        check("sparse_bubble", wb_valid, 0);

        // Reset while an entry is stalled in the output stage
        wb_ready  = 1'b0;
        req_valid = 5'b00001;
        step();
        req_valid = 5'b11111;
        do_reset();
        wb_ready = 1'b1;
        step();
        check("post_rst_idx", wb_idx, 0);

        // Random traffic, including valids that drop without ready
        for (int k = 0; k < 300; k++) begin
            req_valid = N'($urandom_range(0, 31));
            wb_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

`ifdef RV_WB_ARB_PERF_EN
        // GPU stalls for 7 cycles behind a blocked CSR entry
        req_valid = 5'b00000;
        do_reset();
        wb_ready  = 1'b0;
        req_valid = 5'b00100;
        step();
        req_valid = 5'b10000;
        for (int k = 0; k < 7; k++) step();
        for (int i = 0; i < N; i++) begin
            check("perf_stall", perf_stall_cycles[i*32 +: 32], (i == WB_REQ_GPU) ? 7 : 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
